// File: rtl/imem_read_arbiter.sv
// Round-robin arbiter sharing one fixed-latency instruction memory read port
// between CPU fetch (requester 0) and debug/loader read-back (requester 1).
module imem_read_arbiter #(
  parameter int LATENCY = 1,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data
);

  logic               last_grant;
  logic               grant0;
  logic               grant1;
  logic [LATENCY-1:0] tag_valid;
  logic [LATENCY-1:0] tag_owner;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (!rst) begin
      if (req0_valid && req1_valid) begin
        grant0 = last_grant;
        grant1 = !last_grant;
      end else begin
        grant0 = req0_valid;
        grant1 = req1_valid;
      end
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign mem_rd     = grant0 | grant1;
  assign mem_addr   = grant1 ? req1_addr : req0_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (mem_rd) begin
      last_grant <= grant1;
    end
  end

  // Each stage remembers whether a read was issued and who owns it, so the
  // word returning from memory can be steered to the right requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_valid <= '0;
      tag_owner <= '0;
    end else begin
      tag_valid[0] <= mem_rd;
      tag_owner[0] <= grant1;
      for (int i = 1; i < LATENCY; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_owner[i] <= tag_owner[i-1];
      end
    end
  end

  assign rsp0_valid = tag_valid[LATENCY-1] && !tag_owner[LATENCY-1];
  assign rsp1_valid = tag_valid[LATENCY-1] &&  tag_owner[LATENCY-1];
  assign rsp0_data  = mem_data;
  assign rsp1_data  = mem_data;

endmodule

// File: tb/tb_imem_read_arbiter.sv
// Bench for imem_read_arbiter: four instances (LATENCY 1..4) share stimulus and
// are checked every cycle against a cycle-indexed grant log model.
module tb_imem_read_arbiter;
  localparam int NLAT = 4;
  localparam int LOGN = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic        req1_valid = 1'b0;
  logic [31:0] req0_addr = '0;
  logic [31:0] req1_addr = '0;

  logic [NLAT-1:0] req0_ready_v, req1_ready_v, rsp0_valid_v, rsp1_valid_v, mem_rd_v;
  logic [31:0]     rsp0_data_v [NLAT];
  logic [31:0]     rsp1_data_v [NLAT];
  logic [31:0]     mem_addr_v  [NLAT];
  logic [31:0]     mem_data_v  [NLAT];

  int vectors = 0;
  int miscompares = 0;

  // Model state: arbitration history plus a log of what was issued each cycle.
  bit          m_last = 1'b1;
  bit          eg0, eg1;
  int          cyc = -1;
  int          last_rst_cyc = -1;
  bit          log_v [LOGN];
  bit          log_o [LOGN];
  logic [31:0] log_a [LOGN];
  int          idx;
  bit          ev0, ev1;
  logic [31:0] ea, ed;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NLAT; g++) begin : lat
    localparam int L = g + 1;
    logic [L-1:0] mv = '0;
    logic [31:0]  ma [L];
    logic [31:0]  junk = 32'hdead_beef;

    imem_read_arbiter #(.LATENCY(L), .ADDR_W(32), .DATA_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_addr  (req0_addr),
      .req0_ready (req0_ready_v[g]),
      .rsp0_valid (rsp0_valid_v[g]),
      .rsp0_data  (rsp0_data_v[g]),
      .req1_valid (req1_valid),
      .req1_addr  (req1_addr),
      .req1_ready (req1_ready_v[g]),
      .rsp1_valid (rsp1_valid_v[g]),
      .rsp1_data  (rsp1_data_v[g]),
      .mem_rd     (mem_rd_v[g]),
      .mem_addr   (mem_addr_v[g]),
      .mem_data   (mem_data_v[g])
    );

    // Memory model: not reset, so reads issued before a reset still return data.
    always @(posedge clk) begin
      for (int i = L - 1; i > 0; i--) begin
        mv[i] <= mv[i-1];
        ma[i] <= ma[i-1];
      end
      mv[0] <= mem_rd_v[g];
      ma[0] <= mem_addr_v[g];
      junk  <= $urandom;
    end
    assign mem_data_v[g] = mv[L-1] ? (ma[L-1] * 32'd4 + 32'h100) : junk;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : compare
    cyc++;
    if (rst) begin
      eg0 = 1'b0;
      eg1 = 1'b0;
      m_last = 1'b1;
      last_rst_cyc = cyc;
    end else begin
      eg0 = req0_valid && (!req1_valid || m_last);
      eg1 = req1_valid && (!req0_valid || !m_last);
    end
    ea = eg1 ? req1_addr : req0_addr;
    for (int g = 0; g < NLAT; g++) begin
      idx = cyc - (g + 1);
      ev0 = 1'b0;
      ev1 = 1'b0;
      ed  = '0;
      if (idx > last_rst_cyc && log_v[idx % LOGN]) begin
        ev0 = !log_o[idx % LOGN];
        ev1 = log_o[idx % LOGN];
        ed  = log_a[idx % LOGN] * 32'd4 + 32'h100;
      end
      check_output($sformatf("L%0d req0_ready", g + 1), {31'd0, req0_ready_v[g]}, {31'd0, eg0});
      check_output($sformatf("L%0d req1_ready", g + 1), {31'd0, req1_ready_v[g]}, {31'd0, eg1});
      check_output($sformatf("L%0d mem_rd", g + 1), {31'd0, mem_rd_v[g]}, {31'd0, eg0 | eg1});
      if (eg0 | eg1) check_output($sformatf("L%0d mem_addr", g + 1), mem_addr_v[g], ea);
      check_output($sformatf("L%0d rsp0_valid", g + 1), {31'd0, rsp0_valid_v[g]}, {31'd0, ev0});
      check_output($sformatf("L%0d rsp1_valid", g + 1), {31'd0, rsp1_valid_v[g]}, {31'd0, ev1});
      if (ev0) check_output($sformatf("L%0d rsp0_data", g + 1), rsp0_data_v[g], ed);
      if (ev1) check_output($sformatf("L%0d rsp1_data", g + 1), rsp1_data_v[g], ed);
    end
    log_v[cyc % LOGN] = eg0 | eg1;
    log_o[cyc % LOGN] = eg1;
    log_a[cyc % LOGN] = ea;
    if (eg0 | eg1) m_last = eg1;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      if (i == 500 || i == 501) begin
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end else begin
        rst = 1'b0;
        if (req0_valid && eg0) req0_valid = 1'b0;
        if (req1_valid && eg1) req1_valid = 1'b0;
        if (!req0_valid && $urandom_range(0, 99) < 60) begin
          req0_valid = 1'b1;
          req0_addr  = $urandom;
        end
        if (!req1_valid && $urandom_range(0, 99) < 50) begin
          req1_valid = 1'b1;
          req1_addr  = $urandom;
        end
      end
    end
    next_cycle();
    rst = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Contention straight out of reset: requester 0 wins the first tie.
    for (int k = 0; k < 6; k++) begin
      req0_valid = 1'b1;
      req0_addr  = 32'h10;
      req1_valid = 1'b1;
      req1_addr  = 32'h20;
      @(negedge clk);
      check_output("contention mem_addr", mem_addr_v[1], (k % 2) ? 32'h20 : 32'h10);
      if (k >= 2) check_output("contention rsp0_valid", {31'd0, rsp0_valid_v[1]}, {31'd0, (k % 2) == 0});
      next_cycle();
    end
    req1_valid = 1'b0;
    @(negedge clk);
    check_output("contention tail req0_ready", {31'd0, req0_ready_v[0]}, 32'd1);
    next_cycle();
    req0_valid = 1'b0;
    repeat (6) next_cycle();

    // Single requester, back-to-back, latency sweep over all instances.
    for (int k = 0; k < 10; k++) begin
      req0_valid = (k < 4);
      req0_addr  = k;
      @(negedge clk);
      check_output("single req0_ready", {31'd0, req0_ready_v[0]}, {31'd0, k < 4});
      for (int g = 0; g < NLAT; g++) begin
        check_output("single rsp0_valid", {31'd0, rsp0_valid_v[g]},
                     {31'd0, (k >= g + 1) && (k < g + 5)});
        if ((k >= g + 1) && (k < g + 5))
          check_output("single rsp0_data", rsp0_data_v[g], 32'h100 + 32'd4 * (k - g - 1));
        check_output("single rsp1_valid", {31'd0, rsp1_valid_v[g]}, 32'd0);
      end
      next_cycle();
    end

    // Fairness after idle: req1 alone, idle, then a tie goes to requester 0.
    req1_valid = 1'b1;
    req1_addr  = 32'h33;
    @(negedge clk);
    check_output("fair req1 alone", {31'd0, req1_ready_v[0]}, 32'd1);
    next_cycle();
    req1_valid = 1'b0;
    repeat (3) next_cycle();
    req0_valid = 1'b1;
    req0_addr  = 32'h44;
    req1_valid = 1'b1;
    req1_addr  = 32'h55;
    @(negedge clk);
    check_output("fair tie req0_ready", {31'd0, req0_ready_v[0]}, 32'd1);
    check_output("fair tie req1_ready", {31'd0, req1_ready_v[0]}, 32'd0);
    next_cycle();
    req0_valid = 1'b0;
    @(negedge clk);
    check_output("fair second req1_ready", {31'd0, req1_ready_v[0]}, 32'd1);
    next_cycle();
    req1_valid = 1'b0;
    repeat (5) next_cycle();

    // Reset with reads in flight: those reads must never respond.
    req0_valid = 1'b1;
    req0_addr  = 32'h7;
    next_cycle();
    req0_addr  = 32'h8;
    next_cycle();
    req0_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_output("reset rsp0_valid", {28'd0, rsp0_valid_v}, 32'd0);
    check_output("reset mem_rd", {28'd0, mem_rd_v}, 32'd0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    req0_valid = 1'b1;
    req0_addr  = 32'h60;
    req1_valid = 1'b1;
    req1_addr  = 32'h70;
    @(negedge clk);
    check_output("post-reset tie req0_ready", {31'd0, req0_ready_v[1]}, 32'd1);
    check_output("post-reset tie req1_ready", {31'd0, req1_ready_v[1]}, 32'd0);
    check_output("post-reset rsp0_valid c0", {28'd0, rsp0_valid_v}, 32'd0);
    check_output("post-reset rsp1_valid c0", {28'd0, rsp1_valid_v}, 32'd0);
    next_cycle();
    req0_valid = 1'b0;
    @(negedge clk);
    check_output("post-reset req1_ready", {31'd0, req1_ready_v[1]}, 32'd1);
    check_output("post-reset rsp0_valid c1", {31'd0, rsp0_valid_v[1]}, 32'd0);
    check_output("post-reset rsp1_valid c1", {31'd0, rsp1_valid_v[1]}, 32'd0);
    next_cycle();
    req1_valid = 1'b0;
    repeat (4) next_cycle();

    apply_stimulus(1000);
    repeat (6) next_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_read_arbiter.md
# imem_read_arbiter

Round-robin arbiter that shares one pipelined, fixed-latency instruction memory read port between two requesters: requester 0 (CPU fetch) and requester 1 (debug/loader read-back). The arbiter grants at most one read per cycle and forwards the selected address to the memory. It tracks which requester owns each in-flight read and routes the returned word only to that requester. It sits between the CPU core's fetch path and the instruction memory.

## Interface
Parameters:
- LATENCY, 1, memory read latency in cycles (legal 1..4); data for a read issued in cycle t is valid on mem_data in cycle t+LATENCY
- ADDR_W, 32, word-address width
- DATA_W, 32, instruction word width

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, reset is asynchronous and active-high
- req0_valid  in  1  requester 0 read request
- req0_addr  in  ADDR_W  requester 0 word address
- req0_ready  out  1  requester 0 granted this cycle
- rsp0_valid  out  1  requester 0 response valid
- rsp0_data  out  DATA_W  requester 0 response word
- req1_valid, req1_addr, req1_ready, rsp1_valid, rsp1_data: same as requester 0, for requester 1
- mem_rd  out  1  read strobe to memory
- mem_addr  out  ADDR_W  read address to memory
- mem_data  in  DATA_W  memory read data

## Operation
- Transfer: a request is accepted in a cycle where reqN_valid && reqN_ready. A requester holds valid and addr stable until it is accepted.
- Arbitration (combinational, same cycle):
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not in last_grant.
  - Neither valid: no grant; mem_rd=0.
- last_grant register (1 bit):
  - Updates to the granted index on every grant.
  - Resets to 1, so requester 0 wins the first tie.
  - Unchanged in idle cycles.
- mem_rd = grant0 | grant1. mem_addr = addr of the granted requester. When idle, mem_addr = req0_addr; this is don't-care to memory.
- Tag pipeline: LATENCY-stage shift register of {valid, owner}. Stage 0 loads {mem_rd, granted index} every cycle. The final stage drives the response.
- Response routing:
  - rspN_valid = last_stage.valid && last_stage.owner==N.
  - rsp0_data = rsp1_data = mem_data, unmasked; consumers qualify with rspN_valid.
- No backpressure on responses. Requesters always accept rsp. Responses for one requester return in issue order.
- No limit on outstanding reads. Throughput is one read per cycle total.

## Timing
- Reset (async assert, sync release):
  - Tag pipeline valids clear to 0; last_grant=1.
  - rsp0_valid=rsp1_valid=0 immediately.
  - req*_ready and mem_rd follow inputs combinationally. During reset they are forced to 0.
- Reset mid-operation: all in-flight reads are dropped. No rspN_valid is produced for reads issued before reset, even though memory may still return data.
- Latency: grant in cycle t gives rspN_valid in cycle t+LATENCY.
- Contention: with both requesters continuously valid, grants alternate 0,1,0,1… Each requester waits at most 1 cycle.
- Single requester: granted every cycle (back-to-back, 100% throughput).
- Simultaneous events: a new grant in cycle t and a response for an older read in the same cycle are independent. Both occur.
- Requester dropping valid before grant is a protocol violation; behaviour is unspecified.

## Test plan
- Reset: assert rst with reads in flight (LATENCY=2), release → rsp0_valid/rsp1_valid stay 0 for the next 2 cycles; first tie after reset grants requester 0.
- Single requester: req0 valid with addr 0,1,2,3 back-to-back, memory returns addr*4+0x100 → req0_ready=1 every cycle; rsp0_valid on cycles t+2..t+5 with data 0x100,0x104,0x108,0x10C; rsp1_valid never set.
- Contention: both valid continuously for 6 cycles (req0 addr 0x10, req1 addr 0x20) → mem_addr sequence 0x10,0x20,0x10,0x20,0x10,0x20; responses routed alternately to rsp0/rsp1, each LATENCY cycles after its grant.
- Fairness after idle: req1 granted alone, 3 idle cycles, then both valid → requester 0 granted first.
- Latency sweep: repeat the single-requester scenario for LATENCY=1,3,4 → rsp latency equals LATENCY exactly; no lost or duplicated responses.
- Mixed traffic: random valid patterns for 1000 cycles against a scoreboard model → every accepted request yields exactly one response to its owner, in order, with correct data.
